// File: rtl/chan_mux_arb_if.sv
// Handshake bundle between the producers/consumer and chan_mux_arb.
interface chan_mux_arb_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SELW     = $clog2(CHANNELS)
);
  logic                      mode;
  logic [SELW-1:0]           sel;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [SELW-1:0]           out_chan;

  // Producer/consumer side
  modport master (output mode, sel, in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_valid, out_chan);

  // Mux side
  modport slave  (input  mode, sel, in_data, in_valid, out_ready,
                  output in_ready, out_data, out_valid, out_chan);
endinterface

// File: rtl/chan_mux_arb.sv
// N-channel registered mux with fixed-select or round-robin arbitration.
// One output register with a full flag; a new word may load on the same
// edge the held word drains, so throughput is one word per cycle.
module chan_mux_arb #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  chan_mux_arb_if.slave bus
);
  localparam int              SELW = $clog2(CHANNELS);
  localparam logic [SELW-1:0] LAST = SELW'(CHANNELS - 1);

  logic [SELW-1:0]     r_ptr;
  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_data;
  logic [SELW-1:0]     r_out_chan;

  logic                w_can_load;
  logic                w_grant_vld;
  logic [SELW-1:0]     w_grant;
  logic [CHANNELS-1:0] w_in_ready;
  logic [WIDTH-1:0]    w_grant_data;
  logic                w_xfer;

  assign w_can_load = !r_out_valid || bus.out_ready;

  // Grant: the selected channel in fixed mode, else first valid channel from r_ptr
  always_comb begin : grant_sel
    int idx;
    w_grant_vld = 1'b0;
    w_grant     = '0;
    idx         = 0;
    if (!bus.mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
          w_grant_vld = 1'b1;
          w_grant     = SELW'(i);
        end
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        // r_ptr is always below CHANNELS, so one subtraction wraps the scan
        idx = int'(r_ptr) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (!w_grant_vld && bus.in_valid[idx]) begin
          w_grant_vld = 1'b1;
          w_grant     = SELW'(idx);
        end
      end
    end
  end

  // One-hot accept toward the granted channel (silent in reset) and its data
  always_comb begin
    w_in_ready   = '0;
    w_grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_grant == SELW'(i)) begin
        w_in_ready[i] = rst_n && w_can_load && w_grant_vld;
        w_grant_data  = bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_xfer = |(w_in_ready & bus.in_valid);

  // Output register, full flag and round-robin pointer (pointer wraps modulo CHANNELS)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_ptr       <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_grant_data;
      r_out_chan  <= w_grant;
      r_ptr       <= (w_grant == LAST) ? '0 : w_grant + 1'b1;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_chan  = r_out_chan;
endmodule
